// File: rtl/dout_bcd_display_if.sv
// Bus between the register-file DOUT producer (master) and the BCD display block (slave).
// Carries the clock enable, the value to show, the blank control and the display outputs.
interface dout_bcd_display_if;
  logic        enable;
  logic [7:0]  dout_in;
  logic        blank;
  logic        busy;
  logic        bcd_valid;
  logic [11:0] bcd_out;
  logic [6:0]  hex0;
  logic [6:0]  hex1;
  logic [6:0]  hex2;
  logic [6:0]  hex3;

  modport master (
    output enable, dout_in, blank,
    input  busy, bcd_valid, bcd_out, hex0, hex1, hex2, hex3
  );

  modport slave (
    input  enable, dout_in, blank,
    output busy, bcd_valid, bcd_out, hex0, hex1, hex2, hex3
  );
endinterface

// File: rtl/dout_bcd_display.sv
// Sequential double-dabble of the DOUT register into three BCD digits driving 7-segment displays.
// Define SIGNED_DOUT_EN to treat dout_in as two's complement and show a minus sign on hex3.
module dout_bcd_display #(
  parameter bit BLANK_LEADING  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic               clk,
  input logic               resetn,
  dout_bcd_display_if.slave bus
);

  localparam logic [6:0] SegDark  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0] LastIter = 3'd7;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  // Active-low encoding, g..a; polarity is applied afterwards.
  function automatic logic [6:0] seg_enc(input logic [3:0] digit);
    logic [6:0] seg;
    unique case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  function automatic logic [6:0] seg_pol(input logic [6:0] seg_low);
    return SEG_ACTIVE_LOW ? seg_low : ~seg_low;
  endfunction

  function automatic logic [3:0] dabble(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  state_e      r_state,     w_state_nxt;
  logic [7:0]  r_last_val,  w_last_val_nxt;
  logic        r_neg,       w_neg_nxt;
  logic [19:0] r_shift,     w_shift_nxt;
  logic [2:0]  r_iter,      w_iter_nxt;
  logic        r_busy,      w_busy_nxt;
  logic        r_bcd_valid, w_bcd_valid_nxt;
  logic [11:0] r_bcd_out,   w_bcd_out_nxt;
  logic [6:0]  r_hex0,      w_hex0_nxt;
  logic [6:0]  r_hex1,      w_hex1_nxt;
  logic [6:0]  r_hex2,      w_hex2_nxt;
  logic [6:0]  r_hex3,      w_hex3_nxt;

  logic        w_in_neg;
  logic [7:0]  w_in_mag;
  logic [19:0] w_shift_adj;
  logic [19:0] w_step;
  logic [3:0]  w_hund;
  logic [3:0]  w_tens;
  logic [3:0]  w_units;
  logic        w_start;

`ifdef SIGNED_DOUT_EN
  // 8'h80 negates to itself, which reads as 128 unsigned.
  assign w_in_neg = bus.dout_in[7];
  assign w_in_mag = bus.dout_in[7] ? (8'd0 - bus.dout_in) : bus.dout_in;
`else
  assign w_in_neg = 1'b0;
  assign w_in_mag = bus.dout_in;
`endif

  assign w_shift_adj = {dabble(r_shift[19:16]), dabble(r_shift[15:12]), dabble(r_shift[11:8]),
                        r_shift[7:0]};
  assign w_step      = w_shift_adj << 1;
  assign w_hund      = w_step[19:16];
  assign w_tens      = w_step[15:12];
  assign w_units     = w_step[11:8];
  assign w_start     = !r_bcd_valid || (bus.dout_in != r_last_val);

  always_comb begin
    w_state_nxt     = r_state;
    w_last_val_nxt  = r_last_val;
    w_neg_nxt       = r_neg;
    w_shift_nxt     = r_shift;
    w_iter_nxt      = r_iter;
    w_busy_nxt      = r_busy;
    w_bcd_valid_nxt = r_bcd_valid;
    w_bcd_out_nxt   = r_bcd_out;
    w_hex0_nxt      = r_hex0;
    w_hex1_nxt      = r_hex1;
    w_hex2_nxt      = r_hex2;
    w_hex3_nxt      = r_hex3;

    if (bus.enable) begin
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            w_state_nxt    = StShift;
            w_last_val_nxt = bus.dout_in;
            w_neg_nxt      = w_in_neg;
            w_shift_nxt    = {12'd0, w_in_mag};
            w_iter_nxt     = 3'd0;
            w_busy_nxt     = 1'b1;
          end
        end
        StShift: begin
          w_shift_nxt = w_step;
          w_iter_nxt  = r_iter + 3'd1;
          if (r_iter == LastIter) begin
            w_state_nxt     = StIdle;
            w_busy_nxt      = 1'b0;
            w_bcd_valid_nxt = 1'b1;
            w_bcd_out_nxt   = {w_hund, w_tens, w_units};
            w_hex0_nxt      = seg_pol(seg_enc(w_units));
            w_hex1_nxt      = (BLANK_LEADING && (w_hund == 4'd0) && (w_tens == 4'd0)) ?
                              SegDark : seg_pol(seg_enc(w_tens));
            w_hex2_nxt      = (BLANK_LEADING && (w_hund == 4'd0)) ?
                              SegDark : seg_pol(seg_enc(w_hund));
            w_hex3_nxt      = r_neg ? seg_pol(7'h3F) : SegDark;
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= StIdle;
      r_last_val  <= 8'd0;
      r_neg       <= 1'b0;
      r_shift     <= 20'd0;
      r_iter      <= 3'd0;
      r_busy      <= 1'b0;
      r_bcd_valid <= 1'b0;
      r_bcd_out   <= 12'd0;
      r_hex0      <= SegDark;
      r_hex1      <= SegDark;
      r_hex2      <= SegDark;
      r_hex3      <= SegDark;
    end else begin
      r_state     <= w_state_nxt;
      r_last_val  <= w_last_val_nxt;
      r_neg       <= w_neg_nxt;
      r_shift     <= w_shift_nxt;
      r_iter      <= w_iter_nxt;
      r_busy      <= w_busy_nxt;
      r_bcd_valid <= w_bcd_valid_nxt;
      r_bcd_out   <= w_bcd_out_nxt;
      r_hex0      <= w_hex0_nxt;
      r_hex1      <= w_hex1_nxt;
      r_hex2      <= w_hex2_nxt;
      r_hex3      <= w_hex3_nxt;
    end
  end

  // Blank only masks the pins; the stored result survives it.
  assign bus.busy      = r_busy;
  assign bus.bcd_valid = r_bcd_valid;
  assign bus.bcd_out   = r_bcd_out;
  assign bus.hex0      = bus.blank ? SegDark : r_hex0;
  assign bus.hex1      = bus.blank ? SegDark : r_hex1;
  assign bus.hex2      = bus.blank ? SegDark : r_hex2;
  assign bus.hex3      = bus.blank ? SegDark : r_hex3;

endmodule

// File: tb/tb_dout_bcd_display.sv
// Self-checking bench for dout_bcd_display: scoreboard of expected conversions popped on busy fall,
// a vector table of values, and hand sequences for restart, freeze, blank and reset abort.
module tb_dout_bcd_display;

  logic clk = 1'b0;
  logic resetn;

  dout_bcd_display_if bus ();

  dout_bcd_display #(
    .BLANK_LEADING (1'b1),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bcd;
    logic [6:0]  h0;
    logic [6:0]  h1;
    logic [6:0]  h2;
    logic [6:0]  h3;
    int          len;
  } exp_t;

  typedef struct {
    logic [7:0]  din;
    logic [11:0] bcd;
  } vec_t;

  exp_t sc_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_err    = 0;
  int   busy_cnt = 0;
  logic prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Reference by division, independent of the shift-add algorithm.
  function automatic exp_t model(input logic [7:0] din, input int len);
    exp_t e;
    int   mag, h, t, u;
    logic neg;
`ifdef SIGNED_DOUT_EN
    neg = din[7];
    mag = neg ? 256 - int'(din) : int'(din);
`else
    neg = 1'b0;
    mag = int'(din);
`endif
    h = mag / 100;
    t = (mag / 10) % 10;
    u = mag % 10;
    e.bcd = {4'(h), 4'(t), 4'(u)};
    e.h0  = seg(u);
    e.h1  = (h == 0 && t == 0) ? 7'h7F : seg(t);
    e.h2  = (h == 0) ? 7'h7F : seg(h);
    e.h3  = neg ? 7'h3F : 7'h7F;
    e.len = len;
    return e;
  endfunction

  task automatic drive(input logic [7:0] v, input int len);
    @(posedge clk);
    #1;
    bus.dout_in = v;
    sc_q.push_back(model(v, len));
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((sc_q.size() != 0 || bus.busy) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({name, "_drain"}, sc_q.size(), 0);
  endtask

  task automatic check_reset(input string name);
    check({name, "_busy"}, bus.busy, 0);
    check({name, "_valid"}, bus.bcd_valid, 0);
    check({name, "_bcd"}, bus.bcd_out, 0);
    check({name, "_hex0"}, bus.hex0, 7'h7F);
    check({name, "_hex1"}, bus.hex1, 7'h7F);
    check({name, "_hex2"}, bus.hex2, 7'h7F);
    check({name, "_hex3"}, bus.hex3, 7'h7F);
  endtask

  // Monitor: a busy falling edge delivers one result.
  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) begin
        busy_cnt  = 0;
        prev_busy = 1'b0;
      end else begin
        if (bus.busy) begin
          busy_cnt++;
        end else if (prev_busy) begin
          if (sc_q.size() == 0) begin
            check("spurious_result", sc_q.size(), 1);
          end else begin
            mon_e = sc_q.pop_front();
            check("sb_bcd", bus.bcd_out, mon_e.bcd);
            check("sb_valid", bus.bcd_valid, 1);
            check("sb_hex0", bus.hex0, mon_e.h0);
            check("sb_hex1", bus.hex1, mon_e.h1);
            check("sb_hex2", bus.hex2, mon_e.h2);
            check("sb_hex3", bus.hex3, mon_e.h3);
            check("sb_busy_len", busy_cnt, mon_e.len);
          end
          busy_cnt = 0;
        end
        prev_busy = bus.busy;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  vec_t tbl[12];
  exp_t e;

  initial begin
    tbl[0]  = '{8'd1,   12'h001};
    tbl[1]  = '{8'd9,   12'h009};
    tbl[2]  = '{8'd10,  12'h010};
    tbl[3]  = '{8'd99,  12'h099};
    tbl[4]  = '{8'd100, 12'h100};
    tbl[5]  = '{8'd128, 12'h128};
    tbl[6]  = '{8'd199, 12'h199};
    tbl[7]  = '{8'd200, 12'h200};
    tbl[8]  = '{8'd5,   12'h005};
    tbl[9]  = '{8'd50,  12'h050};
    tbl[10] = '{8'd0,   12'h000};
    tbl[11] = '{8'd254, 12'h254};

    resetn      = 1'b0;
    bus.enable  = 1'b0;
    bus.dout_in = 8'd0;
    bus.blank   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");

    // First conversion starts on the first enabled edge after release.
    sc_q.push_back(model(8'd0, 8));
    resetn     = 1'b1;
    bus.enable = 1'b1;
    wait_idle("t1");
    check("t1_bcd", bus.bcd_out, 12'h000);
    check("t1_hex0", bus.hex0, 7'h40);
    check("t1_hex1", bus.hex1, 7'h7F);
    check("t1_hex2", bus.hex2, 7'h7F);

    drive(8'd255, 8);
    wait_idle("t2");
`ifndef SIGNED_DOUT_EN
    check("t2_bcd", bus.bcd_out, 12'h255);
    check("t2_hex2", bus.hex2, 7'h24);
    check("t2_hex1", bus.hex1, 7'h12);
    check("t2_hex0", bus.hex0, 7'h12);
`endif

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].din, 8);
      wait_idle("tbl");
`ifndef SIGNED_DOUT_EN
      check("tbl_bcd", bus.bcd_out, tbl[i].bcd);
`endif
    end

    // A change during SHIFT is picked up only after the running conversion ends.
    drive(8'd7, 8);
    repeat (3) @(posedge clk);
    #1;
    bus.dout_in = 8'd42;
    sc_q.push_back(model(8'd42, 8));
    wait_idle("t3");
    check("t3_bcd", bus.bcd_out, 12'h042);
    check("t3_hex2", bus.hex2, 7'h7F);

    // Freeze for five edges mid-conversion.
    drive(8'd100, 13);
    repeat (3) @(posedge clk);
    #1;
    bus.enable = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t4_busy_frozen", bus.busy, 1);
      check("t4_bcd_held", bus.bcd_out, 12'h042);
      @(posedge clk);
    end
    #1;
    bus.enable = 1'b1;
    wait_idle("t4");
    e = model(8'd100, 0);
    bus.blank = 1'b1;
    @(negedge clk);
    check("t4_blank_hex0", bus.hex0, 7'h7F);
    check("t4_blank_hex1", bus.hex1, 7'h7F);
    check("t4_blank_hex2", bus.hex2, 7'h7F);
    check("t4_blank_hex3", bus.hex3, 7'h7F);
    check("t4_blank_bcd", bus.bcd_out, e.bcd);
    check("t4_blank_valid", bus.bcd_valid, 1);
    bus.blank = 1'b0;
    @(negedge clk);
    check("t4_unblank_hex0", bus.hex0, e.h0);
    check("t4_unblank_hex2", bus.hex2, e.h2);

    // Reset at iter=4 aborts; conversion restarts from dout_in after release.
    drive(8'd150, 8);
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    sc_q.delete();
    #1;
    check_reset("t5_abort");
    @(negedge clk);
    check_reset("t5_held");
    sc_q.push_back(model(8'd150, 8));
    resetn = 1'b1;
    wait_idle("t5");
    check("t5_bcd", bus.bcd_out, model(8'd150, 0).bcd);

`ifdef SIGNED_DOUT_EN
    drive(8'hFF, 8);
    wait_idle("t6a");
    check("t6_ff_bcd", bus.bcd_out, 12'h001);
    check("t6_ff_hex3", bus.hex3, 7'h3F);
    drive(8'h80, 8);
    wait_idle("t6b");
    check("t6_80_bcd", bus.bcd_out, 12'h128);
    check("t6_80_hex3", bus.hex3, 7'h3F);
    drive(8'h05, 8);
    wait_idle("t6c");
    check("t6_pos_hex3", bus.hex3, 7'h7F);
`else
    drive(8'hFF, 8);
    wait_idle("t6u");
    check("t6_ff_bcd", bus.bcd_out, 12'h255);
    check("t6_ff_hex3", bus.hex3, 7'h7F);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
